// File: rtl/spi_reg_arbiter.sv
// Shared status-register image for the SPI read bank. Round-robin writes from
// internal producers, and a LOCK freeze with a timeout so a stuck LOCK cannot starve them.
module spi_reg_arbiter #(
  parameter int NREQ         = 4,
  parameter int NWORDS       = 64,
  parameter int AW           = 6,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 SYS_CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*16-1:0]   REQ_DATA,
  output logic [NREQ-1:0]      GNT,
  input  logic                 LOCK,
  input  logic                 CLR_ERR,
  output logic [NWORDS*16-1:0] REG_IMAGE,
  output logic                 WR_STROBE,
  output logic [AW-1:0]        WR_ADDR,
  output logic                 LOCK_ERR,
  output logic                 ADDR_ERR
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {S_ARB, S_LOCKED, S_OVERRIDE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [NREQ-1:0]          gnt_q, gnt_d;
  logic                     wr_q, wr_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic                     lock_err_q, lock_err_d;
  logic                     addr_err_q, addr_err_d;
  logic [NWORDS-1:0][15:0]  img_q, img_d;

  logic [NREQ-1:0] elig;
  logic            found, grant_en, do_grant, addr_ok, lock_err_set;
  logic [PW-1:0]   win;
  logic [AW-1:0]   win_addr;
  logic [15:0]     win_data;

  // A requester granted last cycle is masked so it cannot win twice in a row.
  always_comb begin
    int idx;
    elig     = REQ & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found    = 1'b1;
        win      = PW'(idx);
        win_addr = REQ_ADDR[idx*AW +: AW];
        win_data = REQ_DATA[idx*16 +: 16];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_en     = 1'b0;
    lock_err_set = 1'b0;
    case (state_q)
      S_ARB: begin
        if (LOCK) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else begin
          grant_en = 1'b1;
        end
      end
      S_LOCKED: begin
        if (!LOCK) begin
          state_d = S_ARB;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d      = S_OVERRIDE;
          lock_err_set = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OVERRIDE: begin
        grant_en = 1'b1;
        if (!LOCK) begin
          state_d = S_ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  // Out-of-range addresses are still granted so the requester is released.
  always_comb begin
    do_grant   = grant_en & found;
    addr_ok    = int'(win_addr) < NWORDS;
    gnt_d      = do_grant ? (NREQ'(1) << win) : '0;
    ptr_d      = ptr_q;
    if (do_grant) ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    wr_d       = do_grant & addr_ok;
    wr_addr_d  = wr_d ? win_addr : wr_addr_q;
    lock_err_d = lock_err_set | (lock_err_q & ~CLR_ERR);
    addr_err_d = (do_grant & ~addr_ok) | (addr_err_q & ~CLR_ERR);
    img_d      = img_q;
    for (int w = 0; w < NWORDS; w++)
      if (wr_d && int'(win_addr) == w) img_d[w] = win_data;
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_ARB;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      lock_err_q <= 1'b0;
      addr_err_q <= 1'b0;
      img_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      lock_err_q <= lock_err_d;
      addr_err_q <= addr_err_d;
      img_q      <= img_d;
    end
  end

  assign GNT       = gnt_q;
  assign WR_STROBE = wr_q;
  assign WR_ADDR   = wr_addr_q;
  assign LOCK_ERR  = lock_err_q;
  assign ADDR_ERR  = addr_err_q;
  assign REG_IMAGE = img_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Scoreboard bench: a cycle model predicts grants/writes into a queue, a
// monitor pops and compares whenever the DUT shows GNT or WR_STROBE.
module tb_spi_reg_arbiter;
  localparam int NREQ = 4;
  localparam int NW   = 48;
  localparam int AW   = 6;
  localparam int LT   = 16;

  logic                 SYS_CLK, RST_N;
  logic [NREQ-1:0]      REQ;
  logic [NREQ*AW-1:0]   REQ_ADDR;
  logic [NREQ*16-1:0]   REQ_DATA;
  logic [NREQ-1:0]      GNT;
  logic                 LOCK, CLR_ERR;
  logic [NW*16-1:0]     REG_IMAGE;
  logic                 WR_STROBE;
  logic [AW-1:0]        WR_ADDR;
  logic                 LOCK_ERR, ADDR_ERR;

  spi_reg_arbiter #(.NREQ(NREQ), .NWORDS(NW), .AW(AW), .LOCK_TIMEOUT(LT)) dut (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .GNT(GNT), .LOCK(LOCK), .CLR_ERR(CLR_ERR),
    .REG_IMAGE(REG_IMAGE), .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR),
    .LOCK_ERR(LOCK_ERR), .ADDR_ERR(ADDR_ERR));

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [NREQ-1:0] gnt;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [15:0]     data;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic [15:0]     m_img [NW];
  int              m_ptr, m_mode, m_lock_edges;
  logic [NREQ-1:0] m_last;
  bit              m_lerr, m_aerr;

  // requester stimulus state
  bit          r_act  [NREQ];
  logic [5:0]  r_addr [NREQ];
  logic [15:0] r_data [NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) m_img[w] = 16'h0;
    m_ptr = 0; m_mode = 0; m_lock_edges = 0; m_last = '0;
    m_lerr = 0; m_aerr = 0;
  endfunction

  // One rising edge of the specified behaviour, computed from the inputs.
  function automatic void model_step();
    bit   may_grant = 0, lset = 0, aset = 0, found = 0;
    int   w = 0, a;
    exp_t e;
    case (m_mode)
      0: if (LOCK) begin m_mode = 1; m_lock_edges = 0; end else may_grant = 1;
      1: if (!LOCK) m_mode = 0;
         else begin
           m_lock_edges++;
           if (m_lock_edges == LT) begin m_mode = 2; lset = 1; end
         end
      default: begin may_grant = 1; if (!LOCK) m_mode = 0; end
    endcase
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (!found && REQ[i] && !m_last[i]) begin found = 1; w = i; end
    end
    m_last = '0;
    if (may_grant && found) begin
      m_last[w] = 1'b1;
      m_ptr = (w + 1) % NREQ;
      a = int'(REQ_ADDR[w*AW +: AW]);
      e.gnt = m_last; e.addr = AW'(a); e.data = REQ_DATA[w*16 +: 16];
      e.wr = (a < NW);
      if (e.wr) m_img[a] = e.data; else aset = 1;
      expq.push_back(e);
    end
    if (CLR_ERR) begin m_lerr = 0; m_aerr = 0; end
    if (lset) m_lerr = 1;
    if (aset) m_aerr = 1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      REQ[i] = r_act[i];
      REQ_ADDR[i*AW +: AW] = r_addr[i];
      REQ_DATA[i*16 +: 16] = r_data[i];
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    model_step();
    @(negedge SYS_CLK);
    #2;
  endtask

  task automatic checkpoint(input string name);
    int bad = -1;
    for (int w = 0; w < NW; w++)
      if (bad < 0 && REG_IMAGE[w*16 +: 16] !== m_img[w]) bad = w;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_image word %0d got %h expected %h", name, bad,
               REG_IMAGE[bad*16 +: 16], m_img[bad]);
    end
    chk({name, "_lock_err"}, 64'(LOCK_ERR), 64'(m_lerr));
    chk({name, "_addr_err"}, 64'(ADDR_ERR), 64'(m_aerr));
    chk({name, "_pending"}, 64'(expq.size()), 64'd0);
  endtask

  function automatic void clear_reqs();
    for (int i = 0; i < NREQ; i++) begin r_act[i] = 0; r_addr[i] = '0; r_data[i] = '0; end
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge SYS_CLK);
      if (RST_N && (GNT != '0 || WR_STROBE)) begin
        if (expq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output gnt=%b wr_strobe=%b expected none at %0t", GNT, WR_STROBE, $time);
        end else begin
          e = expq.pop_front();
          chk("mon_gnt", 64'(GNT), 64'(e.gnt));
          chk("mon_wr_strobe", 64'(WR_STROBE), 64'(e.wr));
          if (e.wr) begin
            chk("mon_wr_addr", 64'(WR_ADDR), 64'(e.addr));
            chk("mon_word", 64'(REG_IMAGE[int'(e.addr)*16 +: 16]), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    int cnt, t_err, t_gnt, lock_left;
    logic [NREQ-1:0] seq [5];
    RST_N = 0; LOCK = 0; CLR_ERR = 0;
    clear_reqs(); drive_reqs();
    model_reset();
    repeat (2) @(posedge SYS_CLK);
    @(negedge SYS_CLK); RST_N = 1; #2;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_gnt", 64'(GNT), 64'd0);
      chk("idle_wr_strobe", 64'(WR_STROBE), 64'd0);
    end
    chk("idle_wr_addr", 64'(WR_ADDR), 64'd0);
    checkpoint("idle");

    // all four requesting, rotation order
    for (int i = 0; i < NREQ; i++) begin r_act[i] = 1; r_addr[i] = 6'(i); r_data[i] = 16'hA000 + 16'(i); end
    drive_reqs();
    for (int c = 0; c < 5; c++) begin tick(); seq[c] = GNT; end
    clear_reqs(); drive_reqs();
    chk("rr_seq0", 64'(seq[0]), 64'b0001);
    chk("rr_seq1", 64'(seq[1]), 64'b0010);
    chk("rr_seq2", 64'(seq[2]), 64'b0100);
    chk("rr_seq3", 64'(seq[3]), 64'b1000);
    chk("rr_seq4", 64'(seq[4]), 64'b0001);
    tick();
    for (int i = 0; i < NREQ; i++) chk("rr_word", 64'(REG_IMAGE[i*16 +: 16]), 64'(16'hA000 + i));
    checkpoint("rr");

    // single requester gets every other cycle
    r_act[2] = 1; r_addr[2] = 6'd5; r_data[2] = 16'h1234; drive_reqs();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (GNT[2]) cnt++; end
    clear_reqs(); drive_reqs(); tick();
    chk("single_grants", 64'(cnt), 64'd5);
    chk("single_word5", 64'(REG_IMAGE[95:80]), 64'h1234);
    checkpoint("single");

    // short lock, request raised on the same edge as LOCK
    LOCK = 1; r_act[1] = 1; r_addr[1] = 6'd9; r_data[1] = 16'hBEEF; drive_reqs();
    for (int c = 0; c < 10; c++) tick();
    chk("lock_hold_gnt", 64'(GNT), 64'd0);
    LOCK = 0;
    tick(); chk("unlock_edge1_gnt", 64'(GNT), 64'd0);
    tick(); chk("unlock_edge2_gnt", 64'(GNT), 64'b0010);
    clear_reqs(); drive_reqs(); tick();
    chk("short_lock_err", 64'(LOCK_ERR), 64'd0);
    checkpoint("short_lock");

    // lock timeout then override
    LOCK = 1; r_act[0] = 1; r_addr[0] = 6'd7; r_data[0] = 16'h5A5A; drive_reqs();
    t_err = -1; t_gnt = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (t_err < 0 && LOCK_ERR) t_err = c;
      if (t_gnt < 0 && GNT[0]) begin t_gnt = c; clear_reqs(); drive_reqs(); end
    end
    chk("timeout_err_edge", 64'(t_err), 64'd17);
    chk("timeout_gnt_edge", 64'(t_gnt), 64'd18);
    checkpoint("timeout");
    LOCK = 0; CLR_ERR = 1; tick(); CLR_ERR = 0;
    chk("clr_lock_err", 64'(LOCK_ERR), 64'd0);

    // out-of-range address, then clear colliding with a new error
    r_act[3] = 1; r_addr[3] = 6'd50; r_data[3] = 16'hDEAD; drive_reqs();
    tick();
    chk("bad_gnt", 64'(GNT), 64'b1000);
    chk("bad_wr_strobe", 64'(WR_STROBE), 64'd0);
    chk("bad_addr_err", 64'(ADDR_ERR), 64'd1);
    CLR_ERR = 1;
    tick(); chk("clr_addr_err", 64'(ADDR_ERR), 64'd0);
    tick(); chk("set_beats_clr", 64'(ADDR_ERR), 64'd1);
    CLR_ERR = 0; clear_reqs(); drive_reqs(); tick();
    checkpoint("bad_addr");

    // reset in the middle of a burst
    for (int i = 0; i < NREQ; i++) begin r_act[i] = 1; r_addr[i] = 6'(10 + i); r_data[i] = 16'(16'hC000 + i); end
    drive_reqs();
    repeat (3) tick();
    RST_N = 0; #1;
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_wr_strobe", 64'(WR_STROBE), 64'd0);
    chk("rst_wr_addr", 64'(WR_ADDR), 64'd0);
    chk("rst_image_zero", 64'(REG_IMAGE != '0), 64'd0);
    expq.delete(); model_reset();
    clear_reqs(); drive_reqs();
    repeat (2) @(posedge SYS_CLK);
    @(negedge SYS_CLK); RST_N = 1; #2;
    checkpoint("after_reset");

    // randomized traffic
    lock_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_act[i] && GNT[i]) begin
          if ($urandom_range(0, 1) == 0) r_act[i] = 0;
          else begin r_addr[i] = 6'($urandom_range(0, 63)); r_data[i] = 16'($urandom); end
        end else if (!r_act[i] && $urandom_range(0, 2) == 0) begin
          r_act[i] = 1; r_addr[i] = 6'($urandom_range(0, 63)); r_data[i] = 16'($urandom);
        end
      end
      drive_reqs();
      if (lock_left > 0) begin LOCK = 1; lock_left--; end
      else begin
        LOCK = 0;
        if ($urandom_range(0, 39) == 0) lock_left = $urandom_range(1, 30);
      end
      CLR_ERR = ($urandom_range(0, 15) == 0);
      tick();
      if (c % 250 == 249) checkpoint("random");
    end
    LOCK = 0; CLR_ERR = 0; clear_reqs(); drive_reqs();
    repeat (3) tick();
    checkpoint("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
